// File: rtl/sync_probe_pkg.sv
// Shared types for the probe packer: record layout, record types and FSM states.
package sync_probe_pkg;

  localparam int TS_W = 27;

  typedef enum logic [3:0] {
    PT_DIVERGE  = 4'd1,
    PT_COMMIT   = 4'd2,
    PT_DONE     = 4'd3,
    PT_OVERFLOW = 4'd4
  } probe_type_e;

  typedef struct packed {
    probe_type_e     ptype;
    logic            side;
    logic [TS_W-1:0] ts;
    logic [31:0]     payload;
  } probe_rec_t;

  typedef enum logic [1:0] {
    ST_SYNC,
    ST_DIVERGED,
    ST_FINISHED
  } fsm_state_e;

  function automatic probe_rec_t make_rec(probe_type_e t, logic side,
                                          logic [TS_W-1:0] ts, logic [31:0] payload);
    probe_rec_t r;
    r.ptype   = t;
    r.side    = side;
    r.ts      = ts;
    r.payload = payload;
    return r;
  endfunction

endpackage

// File: rtl/sync_probe_packer_fifo.sv
// Record FIFO accepting up to two in-order pushes and one pop per edge.
module probe_fifo2w1r #(
  parameter int DEPTH = 8,
  parameter int W     = 64,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [1:0]   push_n,
  input  logic [W-1:0] push_data0,
  input  logic [W-1:0] push_data1,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [AW:0]  free_cnt,
  output logic         empty
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;

  always_comb begin
    wr_d  = wr_q + AW'(push_n);
    rd_d  = rd_q + AW'(pop);
    cnt_d = cnt_q + (AW+1)'(push_n) - (AW+1)'(pop);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage carries no reset; the count alone defines which entries are live.
  always_ff @(posedge clock) begin
    if (push_n != 2'd0) mem_q[wr_q] <= push_data0;
    if (push_n == 2'd2) mem_q[wr_q + AW'(1)] <= push_data1;
  end

  assign head     = mem_q[rd_q];
  assign free_cnt = (AW+1)'(DEPTH) - cnt_q;
  assign empty    = (cnt_q == '0);

endmodule

// File: rtl/sync_probe_packer.sv
// Detects the first DUT/variant enqueue divergence, then packs commit and done
// events into 64-bit probe records streamed through a small FIFO.
module sync_probe_packer
  import sync_probe_pkg::*;
#(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] DONE_INST  = 32'h00302013,
  parameter int          MAX_WINDOW = 4096
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        dut_enq_valid,
  input  logic [31:0] dut_enq_inst,
  input  logic        vnt_enq_valid,
  input  logic [31:0] vnt_enq_inst,
  input  logic        dut_commit_valid,
  input  logic [31:0] dut_commit_inst,
  input  logic        vnt_commit_valid,
  input  logic [31:0] vnt_commit_inst,
  output logic        probe_wen,
  output logic [63:0] probe_write,
  output logic        diverged,
  output logic        finished,
  output logic        timed_out,
  output logic [15:0] drop_count
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int WIN_W = $clog2(MAX_WINDOW) + 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(MAX_WINDOW - 1);

  fsm_state_e      state_q, state_d;
  logic [TS_W-1:0] ts_q, ts_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic            dut_done_q, dut_done_d;
  logic            vnt_done_q, vnt_done_d;
  logic            diverged_q, diverged_d;
  logic            finished_q, finished_d;
  logic            timed_out_q, timed_out_d;
  logic            ovf_pend_q, ovf_pend_d;
  logic            ovf_act_q, ovf_act_d;
  logic [63:0]     ovf_rec_q, ovf_rec_d;
  logic [15:0]     drop_q, drop_d;

  logic [63:0] dut_rec, vnt_rec, cand0, cand1;
  logic [1:0]  n_cand, n_acc, n_drop;
  logic        mismatch, dut_log, vnt_log, dut_hit, vnt_hit;
  logic        pop, ovf_start, fifo_empty;
  logic [AW:0] fifo_free;
  logic [63:0] fifo_head;
  logic [16:0] drop_sum;
  int          avail;

  assign mismatch = (dut_enq_valid != vnt_enq_valid) ||
                    (dut_enq_valid && vnt_enq_valid && (dut_enq_inst != vnt_enq_inst));
  assign dut_hit  = (dut_commit_inst == DONE_INST);
  assign vnt_hit  = (vnt_commit_inst == DONE_INST);
  assign dut_rec  = make_rec(dut_hit ? PT_DONE : PT_COMMIT, 1'b0, ts_q, dut_commit_inst);
  assign vnt_rec  = make_rec(vnt_hit ? PT_DONE : PT_COMMIT, 1'b1, ts_q, vnt_commit_inst);

  assign pop       = ~ovf_act_q & ~fifo_empty;
  assign ovf_start = ovf_pend_q & fifo_empty & ~ovf_act_q;

  always_comb begin
    state_d     = state_q;
    ts_d        = ts_q + TS_W'(1);
    win_d       = win_q;
    dut_done_d  = dut_done_q;
    vnt_done_d  = vnt_done_q;
    diverged_d  = diverged_q;
    finished_d  = finished_q;
    timed_out_d = timed_out_q;
    cand0       = dut_rec;
    cand1       = vnt_rec;
    n_cand      = 2'd0;
    dut_log     = 1'b0;
    vnt_log     = 1'b0;

    case (state_q)
      ST_SYNC: begin
        if (mismatch) begin
          cand0      = make_rec(PT_DIVERGE, 1'b0, ts_q, dut_enq_inst);
          n_cand     = 2'd1;
          state_d    = ST_DIVERGED;
          diverged_d = 1'b1;
          win_d      = '0;
        end
      end
      ST_DIVERGED: begin
        dut_log    = dut_commit_valid & ~dut_done_q;
        vnt_log    = vnt_commit_valid & ~vnt_done_q;
        dut_done_d = dut_done_q | (dut_log & dut_hit);
        vnt_done_d = vnt_done_q | (vnt_log & vnt_hit);
        // Compact candidates so the DUT record always occupies the first slot.
        if (dut_log) begin
          n_cand = vnt_log ? 2'd2 : 2'd1;
        end else if (vnt_log) begin
          cand0  = vnt_rec;
          n_cand = 2'd1;
        end
        win_d = win_q + WIN_W'(1);
        if (dut_done_d && vnt_done_d) begin
          state_d    = ST_FINISHED;
          finished_d = 1'b1;
        end else if (win_q == WIN_LAST) begin
          state_d     = ST_FINISHED;
          finished_d  = 1'b1;
          timed_out_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Drops fall off the tail of the compacted list, so VNT is shed before DUT.
  always_comb begin
    avail = int'(fifo_free) + int'(pop);
    if (avail < int'(n_cand)) n_acc = 2'(avail);
    else                      n_acc = n_cand;
    n_drop   = n_cand - n_acc;
    drop_sum = {1'b0, drop_q} + 17'(n_drop);
    drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    ovf_act_d  = ovf_start;
    ovf_pend_d = (ovf_pend_q & ~ovf_start) | (n_drop != 2'd0);
    ovf_rec_d  = ovf_start ? 64'(make_rec(PT_OVERFLOW, 1'b0, ts_q, {16'b0, drop_q}))
                           : ovf_rec_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_SYNC;
      ts_q        <= '0;
      win_q       <= '0;
      dut_done_q  <= 1'b0;
      vnt_done_q  <= 1'b0;
      diverged_q  <= 1'b0;
      finished_q  <= 1'b0;
      timed_out_q <= 1'b0;
      ovf_pend_q  <= 1'b0;
      ovf_act_q   <= 1'b0;
      ovf_rec_q   <= '0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      ts_q        <= ts_d;
      win_q       <= win_d;
      dut_done_q  <= dut_done_d;
      vnt_done_q  <= vnt_done_d;
      diverged_q  <= diverged_d;
      finished_q  <= finished_d;
      timed_out_q <= timed_out_d;
      ovf_pend_q  <= ovf_pend_d;
      ovf_act_q   <= ovf_act_d;
      ovf_rec_q   <= ovf_rec_d;
      drop_q      <= drop_d;
    end
  end

  probe_fifo2w1r #(
    .DEPTH (FIFO_DEPTH),
    .W     (64)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push_n     (n_acc),
    .push_data0 (cand0),
    .push_data1 (cand1),
    .pop        (pop),
    .head       (fifo_head),
    .free_cnt   (fifo_free),
    .empty      (fifo_empty)
  );

  assign probe_wen   = ovf_act_q | ~fifo_empty;
  assign probe_write = ovf_act_q ? ovf_rec_q : (fifo_empty ? 64'd0 : fifo_head);
  assign diverged    = diverged_q;
  assign finished    = finished_q;
  assign timed_out   = timed_out_q;
  assign drop_count  = drop_q;

endmodule

// File: tb/tb_sync_probe_packer.sv
// Bench for sync_probe_packer: directed phases plus random traffic against a queue-based model.
module tb_sync_probe_packer;
  localparam int DEPTH = 4;
  localparam int MW    = 16;
  localparam logic [31:0] DONE = 32'h00302013;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic dev = 0, vev = 0, dcv = 0, vcv = 0;
  logic [31:0] dei = 0, vei = 0, dci = 0, vci = 0;
  logic probe_wen, diverged, finished, timed_out;
  logic [63:0] probe_write;
  logic [15:0] drop_count;

  initial forever #5 clock = ~clock;

  sync_probe_packer #(
    .FIFO_DEPTH (DEPTH),
    .DONE_INST  (DONE),
    .MAX_WINDOW (MW)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .dut_enq_valid    (dev),
    .dut_enq_inst     (dei),
    .vnt_enq_valid    (vev),
    .vnt_enq_inst     (vei),
    .dut_commit_valid (dcv),
    .dut_commit_inst  (dci),
    .vnt_commit_valid (vcv),
    .vnt_commit_inst  (vci),
    .probe_wen        (probe_wen),
    .probe_write      (probe_write),
    .diverged         (diverged),
    .finished         (finished),
    .timed_out        (timed_out),
    .drop_count       (drop_count)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: record queue plus the sticky flags, advanced once per edge.
  logic [63:0] m_q[$];
  int          m_mode;  // 0 watching, 1 logging, 2 done
  int          m_win, m_drops;
  int unsigned m_ts;
  bit          m_dd, m_vd, m_div, m_fin, m_to, m_pend, m_show;
  logic [63:0] m_ovf;

  function automatic logic [63:0] mrec(int t, bit side, int unsigned ts, logic [31:0] p);
    return {4'(t), side, 27'(ts), p};
  endfunction

  function automatic logic [31:0] rinst();
    logic [31:0] r;
    r = $urandom;
    if (r == DONE) r = r ^ 32'h1;
    return r;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_mode = 0; m_win = 0; m_drops = 0; m_ts = 0;
    m_dd = 0; m_vd = 0; m_div = 0; m_fin = 0; m_to = 0; m_pend = 0; m_show = 0;
    m_ovf = '0;
  endtask

  task automatic model_step();
    logic [63:0] pushes[$];
    bit start, pop;
    int free;
    start = m_pend && (m_q.size() == 0) && !m_show;
    pop   = !m_show && (m_q.size() > 0);
    if (m_mode == 0) begin
      if ((dev != vev) || (dev && vev && dei != vei)) begin
        pushes.push_back(mrec(1, 0, m_ts, dei));
        m_mode = 1; m_div = 1; m_win = 0;
      end
    end else if (m_mode == 1) begin
      if (dcv && !m_dd) begin
        pushes.push_back(mrec((dci == DONE) ? 3 : 2, 0, m_ts, dci));
        if (dci == DONE) m_dd = 1;
      end
      if (vcv && !m_vd) begin
        pushes.push_back(mrec((vci == DONE) ? 3 : 2, 1, m_ts, vci));
        if (vci == DONE) m_vd = 1;
      end
      if (m_dd && m_vd) begin
        m_mode = 2; m_fin = 1;
      end else if (m_win == MW - 1) begin
        m_mode = 2; m_fin = 1; m_to = 1;
      end
      m_win++;
    end
    free = DEPTH - m_q.size() + (pop ? 1 : 0);
    if (pop) void'(m_q.pop_front());
    if (start) m_ovf = mrec(4, 0, m_ts, {16'b0, m_drops[15:0]});
    m_show = start;
    if (start) m_pend = 0;
    foreach (pushes[i]) begin
      if (i < free) m_q.push_back(pushes[i]);
      else begin
        if (m_drops < 65535) m_drops++;
        m_pend = 1;
      end
    end
    m_ts = (m_ts + 1) & 32'h07FF_FFFF;
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [63:0] exp_w;
    exp_w = m_show ? m_ovf : ((m_q.size() > 0) ? m_q[0] : 64'd0);
    chk("wen", probe_wen, m_show || (m_q.size() > 0));
    chk("write", probe_write, exp_w);
    chk("diverged", diverged, m_div);
    chk("finished", finished, m_fin);
    chk("timed_out", timed_out, m_to);
    chk("drop_count", drop_count, m_drops[15:0]);
    $display("cycle t=%0t wen=%0b rec=%h div=%0b fin=%0b to=%0b drops=%0d",
             $time, probe_wen, probe_write, diverged, finished, timed_out, drop_count);
  endtask

  task automatic step();
    @(posedge clock);
    model_step();
    @(negedge clock);
    check_all();
  endtask

  task automatic do_reset();
    #2 reset = 1'b0;
    dev = 0; vev = 0; dcv = 0; vcv = 0;
    #1;
    chk("rst_wen", probe_wen, 0);
    chk("rst_write", probe_write, 0);
    chk("rst_diverged", diverged, 0);
    chk("rst_finished", finished, 0);
    chk("rst_timed_out", timed_out, 0);
    chk("rst_drops", drop_count, 0);
    model_reset();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic same_enq(bit with_commits);
    dev = 1'($urandom_range(0, 1));
    vev = dev;
    dei = rinst();
    vei = dev ? dei : $urandom;
    dcv = with_commits ? 1'($urandom_range(0, 1)) : 1'b0;
    vcv = with_commits ? 1'($urandom_range(0, 1)) : 1'b0;
    dci = rinst();
    vci = rinst();
  endtask

  task automatic force_diverge();
    dev = 1; vev = 1; dei = 32'h00000013; vei = 32'h00100013;
  endtask

  initial begin
    model_reset();
    do_reset();

    // identical streams, commits ignored while watching
    for (int i = 0; i < 1000; i++) begin
      same_enq(1);
      step();
    end

    // divergence at edge 50, done markers at +5 (DUT) and +9 (VNT)
    do_reset();
    for (int i = 0; i < 50; i++) begin
      same_enq(1);
      step();
    end
    force_diverge();
    dcv = 1; vcv = 1;
    step();
    chk("div_type", probe_write[63:60], 4'd1);
    chk("div_side", probe_write[59], 1'b0);
    chk("div_ts", probe_write[58:32], 27'd50);
    chk("div_payload", probe_write[31:0], 32'h00000013);
    chk("div_flag", diverged, 1'b1);
    for (int k = 1; k <= 12; k++) begin
      same_enq(0);
      dcv = 1; vcv = 1;
      dci = (k == 5) ? DONE : rinst();
      vci = (k == 9) ? DONE : rinst();
      step();
      if (k == 8) chk("not_fin_before_vnt_done", finished, 1'b0);
      if (k == 9) chk("fin_after_done", finished, 1'b1);
    end
    chk("done_no_timeout", timed_out, 1'b0);
    for (int i = 0; i < 12; i++) begin
      same_enq(1);
      step();
    end

    // overflow: both sides commit for 10 edges into a 4-deep FIFO
    do_reset();
    for (int i = 0; i < 3; i++) begin
      same_enq(0);
      step();
    end
    force_diverge();
    step();
    for (int k = 0; k < 10; k++) begin
      same_enq(0);
      dcv = 1; vcv = 1; dci = rinst(); vci = rinst();
      step();
    end
    dcv = 0; vcv = 0;
    for (int i = 0; i < 10; i++) step();
    chk("ovf_drop_total", drop_count, 16'd7);

    // timeout: no done marker ever committed
    do_reset();
    for (int i = 0; i < 2; i++) begin
      same_enq(0);
      step();
    end
    force_diverge();
    step();
    for (int k = 1; k <= 25; k++) begin
      same_enq(0);
      dcv = 1'($urandom_range(0, 1)); vcv = 0;
      step();
      if (k == 15) chk("fin_before_window", finished, 1'b0);
      if (k == 16) begin
        chk("fin_at_window", finished, 1'b1);
        chk("timeout_at_window", timed_out, 1'b1);
      end
    end

    // reset with three records queued, then fresh divergence
    do_reset();
    same_enq(0);
    step();
    force_diverge();
    step();
    same_enq(0); dcv = 1; vcv = 1; dci = rinst(); vci = rinst();
    step();
    same_enq(0); dcv = 1; vcv = 1; dci = rinst(); vci = rinst();
    step();
    chk("burst_wen", probe_wen, 1'b1);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      same_enq(0);
      step();
    end
    force_diverge();
    dcv = 0; vcv = 0;
    step();
    chk("rst_ts_restart", probe_write[58:32], 27'd4);

    // random traffic rounds
    for (int r = 0; r < 6; r++) begin
      do_reset();
      for (int i = 0; i < 300; i++) begin
        same_enq(0);
        if ($urandom_range(0, 39) == 0) begin
          if ($urandom_range(0, 1) == 1) vev = ~dev;
          else begin
            dev = 1; vev = 1; vei = dei ^ 32'h100;
          end
        end
        dcv = 1'($urandom_range(0, 1));
        vcv = 1'($urandom_range(0, 1));
        dci = ($urandom_range(0, 7) == 0) ? DONE : rinst();
        vci = ($urandom_range(0, 7) == 0) ? DONE : rinst();
        step();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
